// File: rtl/vec_chunk_fetcher.sv
// ----------------------------------------------------------------------------
// vec_chunk_fetcher
//
// Operand fetch sequencer for the complex vector x constant add/sub datapath.
// Reads two operand vectors (first row from memory A, second row from
// memory B) one chunk of NU elements at a time. The final partial chunk is
// zero-padded. Each chunk pair is offered to the arithmetic controller on a
// valid/ready handshake.
//
// Element k of a chunk occupies bits [k*ELEM_W +: ELEM_W], element 0 at LSB.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a run (only looked at while idle)
//   base_a, base_b      chunk base addresses of the two vectors
//   mem_re              read strobe shared by both memories
//   mem_addr_a/b        chunk read addresses (wrap modulo 2^ADDR_W)
//   mem_rdata_a/b       read data, valid MEM_LAT cycles after mem_re
//   first_row/second_row  registered, padded chunk pair
//   row_valid/row_ready handshake towards the consumer
//   row_last            presented chunk is the final one of the vector
//   chunk_idx           index of the presented chunk
//   busy                run in progress (start accepted .. done cycle)
//   done                one-cycle pulse after the last chunk is accepted
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// READ    | one-cycle read strobe for chunk idx
// WAIT    | counting down memory latency, capture on terminal count
// PRESENT | chunk pair offered, held until accepted
// DONE    | one-cycle completion pulse
// ----------------------------------------------------------------------------
module vec_chunk_fetcher #(
    parameter int N_EQ    = 19,
    parameter int ELEM_W  = 64,
    parameter int NU      = 8,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_a,
    input  logic [ADDR_W-1:0]    base_b,
    output logic                 mem_re,
    output logic [ADDR_W-1:0]    mem_addr_a,
    output logic [ADDR_W-1:0]    mem_addr_b,
    input  logic [NU*ELEM_W-1:0] mem_rdata_a,
    input  logic [NU*ELEM_W-1:0] mem_rdata_b,
    output logic [NU*ELEM_W-1:0] first_row,
    output logic [NU*ELEM_W-1:0] second_row,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 row_last,
    output logic [31:0]          chunk_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int CHUNKS = (N_EQ + NU - 1) / NU;
    localparam int TAIL   = N_EQ - (CHUNKS - 1) * NU;
    localparam int ROW_W  = NU * ELEM_W;
    localparam int LAT_W  = $clog2(MEM_LAT + 1);

    localparam logic [31:0]      LAST_IDX = 32'(CHUNKS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state;
    logic [31:0]       idx;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ROW_W-1:0]  row_a;
    logic [ROW_W-1:0]  row_b;
    logic [ROW_W-1:0]  tail_mask;
    logic              is_last;

    // Keeps elements 0..TAIL-1 of the final chunk; all ones when N_EQ is a
    // multiple of NU, so no padding happens in that case.
    always_comb begin
        tail_mask = '0;
        for (int k = 0; k < NU; k++) begin
            if (k < TAIL) begin
                tail_mask[k*ELEM_W +: ELEM_W] = {ELEM_W{1'b1}};
            end
        end
    end

    assign is_last = (idx == LAST_IDX);

    // The chunk addresses are carried as running registers (loaded with the
    // base on start, stepped on every non-final handshake) so they wrap
    // naturally and stay at zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            addr_a  <= '0;
            addr_b  <= '0;
            lat_cnt <= '0;
            row_a   <= '0;
            row_b   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_a <= base_a;
                        addr_b <= base_b;
                        idx    <= '0;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        if (is_last) begin
                            row_a <= mem_rdata_a & tail_mask;
                            row_b <= mem_rdata_b & tail_mask;
                        end else begin
                            row_a <= mem_rdata_a;
                            row_b <= mem_rdata_b;
                        end
                        state <= S_PRESENT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (row_ready) begin
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            idx    <= idx + 32'd1;
                            addr_a <= addr_a + ADDR_W'(1);
                            addr_b <= addr_b + ADDR_W'(1);
                            state  <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_re     = (state == S_READ);
    assign mem_addr_a = addr_a;
    assign mem_addr_b = addr_b;
    assign first_row  = row_a;
    assign second_row = row_b;
    assign row_valid  = (state == S_PRESENT);
    assign row_last   = (state == S_PRESENT) && is_last;
    assign chunk_idx  = idx;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule
